// File: rtl/counter_capture.sv
// Timestamp capture: samples count on each rising edge of trigger into a small
// FIFO and drains it over a valid/ready handshake, with a sticky overflow flag.
module counter_capture #(
    parameter int Size  = 5,
    parameter int Depth = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [Size-1:0]          count,
    input  logic                     trigger,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [Size-1:0]          out_data,
    output logic [$clog2(Depth):0]   level,
    output logic                     overflow,
    input  logic                     clear_overflow
);

    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] FULL = AW'(0) + (AW+1)'(Depth);

    logic [Size-1:0] mem_q [Depth];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [Size-1:0] data_q, data_d;
    logic            overflow_q, overflow_d;
    logic            trig_q;
    logic            cap, pop, push, drop;

    always_comb begin
        cap  = trigger & ~trig_q;
        pop  = (level_q != '0) & out_ready;
        push = cap & ((level_q != FULL) | pop);
        drop = cap & ~push;

        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d    = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        overflow_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);

        // Registered head: the new head may be the entry being written this cycle.
        data_d = data_q;
        if (level_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d))
                data_d = count;
            else
                data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_ptr_q] <= count;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            trig_q     <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            trig_q     <= trigger;
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = data_q;
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule
